uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive end of the UART link: deserialises the 8N1 stream produced by uart_tx and buffers the bytes in a small first-word-fall-through FIFO.
- Consumer side uses a valid/ready handshake.
- Detects start-bit glitches, framing errors and FIFO overrun.
- Sits between the board RX pin and the byte consumer; drop-in companion to uart_tx with the same bit-timing parameter.

Parameters:
- no_clk_per_bit, 104, clocks per bit (clock freq / baud); minimum 4.
- FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- serial_in  in  1  asynchronous serial line; idles high.
- data_out  out  8  byte at FIFO head.
- data_valid  out  1  FIFO non-empty; data_out is meaningful.
- data_ready  in  1  consumer accepts head byte when high together with data_valid.
- fifo_count  out  ADDR_W+1  bytes held, 0..FIFO_DEPTH.
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte dropped because FIFO full.
- parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 when parity is not compiled in).

Behaviour:
- Single clock domain; i_rst_n is asynchronous and active-low.
- Reset values:
  - FSM in IDLE; counters and bit index 0; shift register 0x00.
  - FIFO empty, so data_valid=0 and fifo_count=0; data_out=0x00.
  - framing_err, overrun, parity_err all 0.
  - Synchroniser flops reset to 1.
- Reset mid-frame aborts the frame with no pulse and flushes the FIFO.
- serial_in passes through a 2-flop synchroniser; all decisions use the synchronised bit rx_s (2-cycle latency).
- Bit counter clk_cnt counts 0..no_clk_per_bit-1.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: clk_cnt=0. On rx_s==0 -> START.
  - START: when clk_cnt==(no_clk_per_bit-1)/2:
    - rx_s==0 -> DATA, with clk_cnt=0 and bit_idx=0.
    - rx_s==1 -> IDLE (glitch; no pulse).
  - DATA: when clk_cnt==no_clk_per_bit-1, sample rx_s into bit[bit_idx], LSB first, and clear clk_cnt. After bit 7 -> PARITY if compiled in, else STOP.
  - STOP: when clk_cnt==no_clk_per_bit-1:
    - rx_s==1 and no parity error: push the byte -> IDLE.
    - rx_s==0: framing_err=1 for one cycle; byte discarded -> IDLE.
  - Returning to IDLE at mid-stop-bit is intentional; the next start edge is accepted immediately.
- Push rules:
  - Push occurs in the cycle the stop bit is sampled.
  - The byte is visible at data_out, with data_valid=1, the following cycle when the FIFO was empty.
  - Full and no pop in the same cycle: byte dropped, overrun=1 for one cycle, FIFO unchanged.
  - Full with a pop in the same cycle: push accepted, count stays FIFO_DEPTH.
- Pop rules:
  - Pop occurs when data_valid && data_ready; the head advances next cycle.
  - data_ready while empty has no effect.
- Simultaneous push and pop when non-empty: count unchanged, ordering preserved.
- Read/write pointers are ADDR_W bits and wrap modulo FIFO_DEPTH.
- fifo_count = number of entries; it never exceeds FIFO_DEPTH.
- Error pulses never coincide with a push for the same frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: one even-parity bit follows data bit 7.
  - PARITY state samples it at clk_cnt==no_clk_per_bit-1.
  - Mismatch: parity_err pulses one cycle at the stop-bit sample, and the byte is discarded even if the stop bit is good.
  - If both parity and stop bit are bad, both error pulses fire in the same cycle.
- Not defined:
  - No PARITY state; frame is 8N1.
  - parity_err is constant 0.

Test Plan:
- Loopback: uart_tx sends 0xAB with no_clk_per_bit=104 and a 1000 ns clock; data_ready=1 -> data_valid rises ~9.5 bit-times after the start edge, data_out=0xAB, one pop, fifo_count returns to 0.
- Back-to-back burst: send 0x01, 0x02, 0x03, 0x04, 0x05 with data_ready=0 -> fifo_count reaches 4, overrun pulses once on 0x05. Then hold data_ready=1 -> reads 0x01..0x04 in order, fifo_count=0.
- Glitch: drive serial_in low for 20 clocks, then high -> FSM returns to IDLE, no data_valid, no error pulses.
- Framing error: hand-drive 0x5A with the stop bit low -> framing_err single pulse, fifo_count stays 0. A following valid 0x3C is received correctly.
- Reset mid-frame: assert i_rst_n=0 during data bit 4 of 0xFF, release -> all outputs at reset values. Next frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> parity_err pulse, no push. Send 0x07 with parity bit 1 -> data_out=0x07.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO and valid/ready drain.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity check and parity_err pulse.
module uart_rx_fifo #(
  parameter int no_clk_per_bit = 104,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_W         = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              serial_in,
  output logic [7:0]        data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              framing_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CW = $clog2(no_clk_per_bit);
  localparam logic [CW-1:0] CNT_LAST = CW'(no_clk_per_bit - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'((no_clk_per_bit - 1) / 2);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_n;
  logic [1:0]      sync;
  logic            rx_s;
  logic [CW-1:0]   clk_cnt, clk_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            push_req, fe_set;
`ifdef UART_RX_PARITY_EN
  logic            par_bad, par_bad_n, pe_set;
`endif

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, pop, push_ok, ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= '1;
    else          sync <= {sync[0], serial_in};
  end

  assign rx_s = sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push_req  = 1'b0;
    fe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    pe_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (clk_cnt == CNT_MID) begin
          clk_cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n        = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          par_bad_n = rx_s ^ (^shift);
          state_n   = STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught at once.
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          state_n   = IDLE;
          fe_set    = !rx_s;
`ifdef UART_RX_PARITY_EN
          pe_set    = par_bad;
          push_req  = rx_s && !par_bad;
`else
          push_req  = rx_s;
`endif
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign full       = (fifo_count == FULL_CNT);
  assign data_valid = (fifo_count != '0);
  assign pop        = data_valid && data_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok    = push_req && (!full || pop);
  assign ovf        = push_req && full && !pop;
  assign data_out   = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem        <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= fe_set;
      overrun     <= ovf;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_err <= 1'b0;
    else          parity_err <= pe_set;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: serial frames driven bit by bit, scored against a byte-queue model.
// Honours UART_RX_PARITY_EN to switch between 8N1 and 8E1 frames.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT_LO = CPB * (NB - 1) + CPB / 2;
  localparam int LAT_HI = LAT_LO + 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          serial;
  logic          data_ready;
  logic [7:0]    data_out;
  logic          data_valid;
  logic [AW:0]   fifo_count;
  logic          framing_err, overrun, parity_err;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    exp_q[$];
  int unsigned   cyc = 0;
  int unsigned   rise_cyc = 0;
  int unsigned   start_cyc = 0;
  int            fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int            exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic          prev_valid = 1'b0;

  uart_rx_fifo #(
    .no_clk_per_bit(CPB),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W(AW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .serial_in(serial),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .fifo_count(fifo_count),
    .framing_err(framing_err),
    .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (data_valid && !prev_valid) rise_cyc = cyc;
      if (data_valid && data_ready) begin
        check("pop_model_has_byte", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("pop_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      fe_cnt += int'(framing_err);
      ov_cnt += int'(overrun);
      pe_cnt += int'(parity_err);
    end
    prev_valid = data_valid;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Frame outcome from the protocol rules: good frames queue unless full and not draining.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    logic par_ok;
    par_ok = PAR ? (par_bit == even_par(d)) : 1'b1;
    exp_fe = int'(!stop_bit);
    exp_pe = int'(!par_ok);
    exp_ov = 0;
    if (stop_bit && par_ok) begin
      if (!data_ready && exp_q.size() == DEPTH) exp_ov = 1;
      else exp_q.push_back(d);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                            input int unsigned cut);
    logic bits [NB];
    bits[0] = 1'b0;
    for (int unsigned i = 0; i < 8; i++) bits[i+1] = d[i];
    if (PAR) bits[9] = par_bit;
    bits[NB-1] = stop_bit;
    start_cyc = cyc;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b == cut) break;
      if (b == NB - 1) model_frame(d, stop_bit, par_bit);
      serial = bits[b];
      repeat (CPB) tick();
    end
    if (cut >= NB) serial = 1'b1;
  endtask

  task automatic frame_and_check(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                                 input int unsigned gap);
    int fe0, ov0, pe0;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    send_frame(d, stop_bit, par_bit, NB);
    repeat (gap) tick();
    check("framing_err_pulses", fe_cnt - fe0, exp_fe);
    check("overrun_pulses", ov_cnt - ov0, exp_ov);
    check("parity_err_pulses", pe_cnt - pe0, exp_pe);
    check("fifo_count", {29'd0, fifo_count}, exp_q.size());
    check("data_valid", {31'd0, data_valid}, {31'd0, exp_q.size() != 0});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
    check({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
    check({tag, "_data"}, {24'd0, data_out}, 32'd0);
    check({tag, "_pulses"}, {29'd0, framing_err, overrun, parity_err}, 32'd0);
  endtask

  initial begin
    int fe0, ov0, pe0;
    logic [7:0] d;
    logic sb, pb;

    rst_n = 1'b0;
    serial = 1'b1;
    data_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) tick();

    // Single byte, consumer ready; also checks mid-stop-bit latency.
    data_ready = 1'b1;
    rise_cyc = 0;
    frame_and_check(8'hAB, 1'b1, even_par(8'hAB), CPB);
    check("valid_latency_in_window",
          {31'd0, (rise_cyc - start_cyc >= LAT_LO) && (rise_cyc - start_cyc <= LAT_HI)}, 32'd1);

    // Back-to-back burst into a stalled consumer: fifth byte overruns.
    data_ready = 1'b0;
    for (int unsigned i = 1; i <= 5; i++)
      frame_and_check(8'(i), 1'b1, even_par(8'(i)), 0);
    repeat (CPB) tick();
    data_ready = 1'b1;
    repeat (10) tick();
    check("burst_drained_count", {29'd0, fifo_count}, exp_q.size());
    check("burst_model_empty", exp_q.size(), 32'd0);

    // Short low glitch on the line.
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    serial = 1'b0;
    repeat (3) tick();
    serial = 1'b1;
    repeat (2 * CPB) tick();
    check("glitch_count", {29'd0, fifo_count}, 32'd0);
    check("glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 32'd0);

    // Bad stop bit, then a good frame.
    data_ready = 1'b0;
    frame_and_check(8'h5A, 1'b0, even_par(8'h5A), CPB);
    frame_and_check(8'h3C, 1'b1, even_par(8'h3C), CPB);
    data_ready = 1'b1;
    repeat (4) tick();

    // Reset during data bit 4 flushes a held byte and the partial frame.
    data_ready = 1'b0;
    frame_and_check(8'h11, 1'b1, even_par(8'h11), CPB);
    send_frame(8'hFF, 1'b1, 1'b0, 5);
    serial = 1'b1;
    repeat (CPB / 2) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_reset_outputs("after_reset");
    data_ready = 1'b1;
    frame_and_check(8'h81, 1'b1, even_par(8'h81), CPB);

`ifdef UART_RX_PARITY_EN
    frame_and_check(8'h07, 1'b1, 1'b0, CPB);
    frame_and_check(8'h07, 1'b1, 1'b1, CPB);
    frame_and_check(8'h07, 1'b0, 1'b0, CPB);
`endif

    // Random frames with occasional bad stop/parity bits and a random consumer.
    for (int n = 0; n < 30; n++) begin
      data_ready = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pb = even_par(d) ^ (PAR && ($urandom_range(0, 5) == 0));
      frame_and_check(d, sb, pb, CPB + $urandom_range(0, 7));
    end

    data_ready = 1'b1;
    repeat (10) tick();
    check("final_count", {29'd0, fifo_count}, exp_q.size());
    check("final_model_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
